// File: rtl/divider_seq.sv
// divider_seq: restoring shift-subtract divider, one quotient bit per clock, valid/ready on both sides.
// Define DIVIDER_SEQ_SIGNED_EN for two's-complement operands with truncating sign correction.
module divider_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] q_reg, rem_reg, dvs, a_in, b_in, q_step, r_step, q_fin, r_fin;
  logic [CW-1:0] cnt;
  logic [N:0] t, d;
  logic dz, accept, last;
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid & in_ready;
  assign last        = (cnt == '0);
  assign quotient    = q_reg;
  assign remainder   = rem_reg;
  assign div_by_zero = dz;
  assign t      = {rem_reg, q_reg[N-1]};
  assign d      = t - {1'b0, dvs};
  assign q_step = {q_reg[N-2:0], ~d[N]};
  assign r_step = d[N] ? t[N-1:0] : d[N-1:0];
`ifdef DIVIDER_SEQ_SIGNED_EN
  logic neg_q, neg_r;
  assign a_in  = dividend[N-1] ? -dividend : dividend;
  assign b_in  = divisor[N-1] ? -divisor : divisor;
  // signs are folded back in on the final BUSY edge so DONE sees corrected values
  assign q_fin = (last && neg_q) ? -q_step : q_step;
  assign r_fin = (last && neg_r) ? -r_step : r_step;
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[N-1] ^ divisor[N-1];
      neg_r <= dividend[N-1];
    end
  end
`else
  assign a_in  = dividend;
  assign b_in  = divisor;
  assign q_fin = q_step;
  assign r_fin = r_step;
`endif
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE)      state_nx = accept ? ((divisor == '0) ? DONE : BUSY) : IDLE;
    else if (state == BUSY) state_nx = last ? DONE : BUSY;
    else                    state_nx = out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q_reg   <= '0;
      rem_reg <= '0;
      dvs     <= '0;
      cnt     <= '0;
      dz      <= 1'b0;
    end else if (accept) begin
      dvs <= b_in;
      cnt <= CW'(N - 1);
      dz  <= (divisor == '0);
      q_reg   <= (divisor == '0) ? '1 : a_in;
      rem_reg <= (divisor == '0) ? dividend : '0;
    end else if (state == BUSY) begin
      q_reg   <= q_fin;
      rem_reg <= r_fin;
      cnt     <= last ? cnt : cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: randomized and directed checks of divider_seq against an arithmetic reference model.
module tb_divider_seq;
  localparam int N = 4;
  logic clk = 1'b0, rstb = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero;
  logic [N-1:0] quotient, remainder;
  logic [N-1:0] exp_q, exp_r;
  logic exp_dz;
  bit exp_set = 1'b0;
  int tests = 0, fails = 0;

  divider_seq #(.N(N)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
`ifdef DIVIDER_SEQ_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = (b == '0);
    if (dz) begin q = '1; r = a; end
    else if (sa == -(1 << (N - 1)) && sb == -1) begin q = a; r = '0; end
    else begin q = N'(sa / sb); r = N'(sa % sb); end
`else
    dz = (b == '0);
    if (dz) begin q = '1; r = a; end
    else begin q = a / b; r = a % b; end
`endif
  endfunction

  always @(negedge clk) if (rstb) begin
    chk("ready_valid_exclusive", int'(in_ready & out_valid), 0);
    if (out_valid && exp_set) begin
      chk("quotient", quotient, exp_q);
      chk("remainder", remainder, exp_r);
      chk("div_by_zero", div_by_zero, exp_dz);
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall, input bit early,
                       input bit lit, input logic [N-1:0] lq, input logic [N-1:0] lr, input bit ldz);
    int lat;
    @(negedge clk);
    model(a, b, exp_q, exp_r, exp_dz);
    exp_set = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'($urandom_range(0, 1));
    dividend = N'($urandom); divisor = N'($urandom);
    lat = 0;
    while (!out_valid && lat < 4 * N) begin @(posedge clk); #1; lat++; end
    in_valid = 1'b0;
    chk("latency", lat, (b == '0) ? 0 : N);
    if (lit) begin
      chk("lit_quotient", quotient, lq);
      chk("lit_remainder", remainder, lr);
      chk("lit_div_by_zero", div_by_zero, ldz);
    end
    if (!early) begin
      repeat (stall) begin
        @(posedge clk); #1;
        in_valid = 1'b1; dividend = N'($urandom); divisor = N'($urandom);
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_handoff_valid", out_valid, 0);
    chk("post_handoff_ready", in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk); rstb = 1'b1;
`ifdef DIVIDER_SEQ_SIGNED_EN
    do_op(4'b1001, 4'd2, 0, 1'b0, 1'b1, 4'b1101, 4'b1111, 1'b0);
    do_op(4'd7, 4'b1110, 1, 1'b0, 1'b1, 4'b1101, 4'd1, 1'b0);
    do_op(4'b1000, 4'b1111, 0, 1'b1, 1'b1, 4'b1000, 4'd0, 1'b0);
    do_op(4'b1011, 4'd0, 2, 1'b0, 1'b1, 4'b1111, 4'b1011, 1'b1);
`else
    do_op(4'd13, 4'd3, 0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0);
    do_op(4'd15, 4'd1, 0, 1'b1, 1'b1, 4'd15, 4'd0, 1'b0);
    do_op(4'd0, 4'd7, 1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
    do_op(4'd5, 4'd9, 0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0);
    do_op(4'd7, 4'd0, 0, 1'b0, 1'b1, 4'b1111, 4'd7, 1'b1);
    do_op(4'd6, 4'd2, 0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0);
    do_op(4'd11, 4'd4, 5, 1'b0, 1'b1, 4'd2, 4'd3, 1'b0);
`endif
    @(negedge clk);
    exp_set = 1'b0;
    dividend = 4'd13; divisor = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #2;
    rstb = 1'b0; #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    @(negedge clk); rstb = 1'b1;
`ifdef DIVIDER_SEQ_SIGNED_EN
    do_op(4'd9, 4'd2, 0, 1'b0, 1'b0, '0, '0, 1'b0);
`else
    do_op(4'd9, 4'd2, 0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0);
`endif
    for (int i = 0; i < 256; i++)
      do_op(N'(i >> 4), N'(i), 0, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 100; i++)
      do_op(N'($urandom), ($urandom_range(0, 7) == 0) ? '0 : N'($urandom),
            $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
